// File: rtl/xalu_defs.sv
// Shared definitions for the multiply/divide unit (XALU).
// Holds the XALUOp encoding, the 4-bit op width and the default cycle
// counts. The E-stage controller, the stall unit and the decoder all
// import this package so the op encoding lives in exactly one place.
package xalu_defs;

  localparam int XALU_OP_W = 4;

  typedef enum logic [XALU_OP_W-1:0] {
    XALU_NONE  = 4'd0,
    XALU_MULT  = 4'd1,
    XALU_MULTU = 4'd2,
    XALU_DIV   = 4'd3,
    XALU_DIVU  = 4'd4,
    XALU_MTHI  = 4'd5,
    XALU_MTLO  = 4'd6,
    XALU_MFHI  = 4'd7,
    XALU_MFLO  = 4'd8
  } xalu_op_t;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // True for the four ops that occupy the unit for several cycles.
  function automatic logic is_start_op(input logic [XALU_OP_W-1:0] op);
    return (op == XALU_MULT) || (op == XALU_MULTU) ||
           (op == XALU_DIV)  || (op == XALU_DIVU);
  endfunction

endpackage

// File: rtl/xalu_arith.sv
// Combinational arithmetic for the XALU.
// Ports:
//   op          in  4   XALUOp code (only mult/multu/div/divu produce a result)
//   rs, rt      in  32  operands
//   result      out 64  {hi, lo}
//   div_by_zero out 1   div/divu with rt == 0
module xalu_arith
  import xalu_defs::*;
(
  input  logic [XALU_OP_W-1:0] op,
  input  logic [31:0]          rs,
  input  logic [31:0]          rt,
  output logic [63:0]          result,
  output logic                 div_by_zero
);

  logic signed [63:0] smul;
  logic        [63:0] umul;
  logic        [31:0] rt_udiv;
  logic        [31:0] rt_sdiv;
  logic signed [31:0] squo;
  logic signed [31:0] srem;
  logic        [31:0] uquo;
  logic        [31:0] urem;
  logic               sdiv_ovf;

  assign smul = $signed(rs) * $signed(rt);
  assign umul = {32'd0, rs} * {32'd0, rt};

  // Divisors are steered away from 0 (and away from -1 for the
  // 0x80000000 / -1 overflow case) so the dividers never see an
  // undefined operation. Dividing by 1 in the overflow case yields
  // exactly the architectural answer: quotient 0x80000000, remainder 0.
  assign sdiv_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);
  assign rt_udiv  = (rt == 32'd0) ? 32'd1 : rt;
  assign rt_sdiv  = ((rt == 32'd0) || sdiv_ovf) ? 32'd1 : rt;

  assign squo = $signed(rs) / $signed(rt_sdiv);
  assign srem = $signed(rs) % $signed(rt_sdiv);
  assign uquo = rs / rt_udiv;
  assign urem = rs % rt_udiv;

  always_comb begin
    result      = 64'd0;
    div_by_zero = 1'b0;
    case (op)
      XALU_MULT:  result = smul;
      XALU_MULTU: result = umul;
      XALU_DIV: begin
        result      = {srem, squo};
        div_by_zero = (rt == 32'd0);
      end
      XALU_DIVU: begin
        result      = {urem, uquo};
        div_by_zero = (rt == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/xalu_ctrl.sv
// E-stage sequencing controller for the multiply/divide unit.
// The result is computed in the start cycle and parked in pend_hi/pend_lo;
// a down-counter models the fixed latency and the parked result is
// committed to HI/LO on the edge where the counter reaches zero.
// Ports:
//   clk        in  1   pipeline clock
//   reset      in  1   synchronous active-low reset
//   xalu_op_e  in  4   E-stage XALUOp
//   rs_e, rt_e in  32  forwarded operands
//   flush      in  1   abort in-flight op, ignore current E op
//   busy       out 1   op in flight or starting (to stall unit)
//   hi, lo     out 32  architectural HI/LO
//   rd_data    out 32  HI for mfhi, otherwise LO
//
// state      | meaning
// cnt == 0   | idle: may start, mthi/mtlo accepted
// cnt != 0   | in flight: cycles left until commit
module xalu_ctrl
  import xalu_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XALU_OP_W-1:0] xalu_op_e,
  input  logic [31:0]          rs_e,
  input  logic [31:0]          rt_e,
  input  logic                 flush,
  output logic                 busy,
  output logic [31:0]          hi,
  output logic [31:0]          lo,
  output logic [31:0]          rd_data
);

  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_valid;
  logic        start;
  logic        idle;
  logic        is_mult;
  logic [63:0] result;
  logic        div_by_zero;

  xalu_arith u_arith (
    .op          (xalu_op_e),
    .rs          (rs_e),
    .rt          (rt_e),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  assign idle    = (cnt == 4'd0);
  assign is_mult = (xalu_op_e == XALU_MULT) || (xalu_op_e == XALU_MULTU);
  // Gated by reset so a start op held during reset never raises busy.
  assign start   = is_start_op(xalu_op_e) && idle && !flush && reset;
  assign busy    = start || !idle;
  assign rd_data = (xalu_op_e == XALU_MFHI) ? hi : lo;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= 4'd0;
      pend_hi    <= 32'd0;
      pend_lo    <= 32'd0;
      pend_valid <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
    end else if (flush) begin
      cnt        <= 4'd0;
      pend_valid <= 1'b0;
    end else begin
      if (start) begin
        pend_hi    <= result[63:32];
        pend_lo    <= result[31:0];
        pend_valid <= !div_by_zero;
        cnt        <= is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      end else if (!idle) begin
        cnt <= cnt - 4'd1;
        if ((cnt == 4'd1) && pend_valid) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
      // Moves only land while idle; in flight they are dropped.
      if (idle && (xalu_op_e == XALU_MTHI)) hi <= rs_e;
      if (idle && (xalu_op_e == XALU_MTLO)) lo <= rs_e;
    end
  end

endmodule
